// File: rtl/top.sv
// Keypad-to-motor sequencer: scans a 4x4 keypad, buffers three keys on a multiplexed 7-segment
// display and replays them as timed motor pulses. Optional macro: KEYPAD_DEBOUNCE_EN.
module top #(
  parameter int SCAN_DIV    = 1,
  parameter int REFRESH_DIV = 4,
  parameter int MOTOR_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] col,
  input  logic       enter,
  output logic [2:0] Motores,
  output logic [6:0] segmentos,
  output logic [2:0] enable
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] REF_LAST  = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] TICK_LAST = 16'(MOTOR_TICKS - 1);
  localparam logic [15:0] REL_LAST  = 16'(4 * SCAN_DIV - 1);

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'h1;
      4'd1:    key_code = 4'h2;
      4'd2:    key_code = 4'h3;
      4'd3:    key_code = 4'hA;
      4'd4:    key_code = 4'h4;
      4'd5:    key_code = 4'h5;
      4'd6:    key_code = 4'h6;
      4'd7:    key_code = 4'hB;
      4'd8:    key_code = 4'h7;
      4'd9:    key_code = 4'h8;
      4'd10:   key_code = 4'h9;
      4'd11:   key_code = 4'hC;
      4'd13:   key_code = 4'h0;
      4'd15:   key_code = 4'hD;
      default: key_code = 4'h0;
    endcase
  endfunction

  // '*' sits at index 12 and '#' at index 14; both are never stored.
  function automatic logic key_storable(input logic [3:0] idx);
    key_storable = (idx != 4'd12) && (idx != 4'd14);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] code);
    case (code)
      4'h0:    seg7 = 7'h3F;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5B;
      4'h3:    seg7 = 7'h4F;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6D;
      4'h6:    seg7 = 7'h7D;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h6F;
      4'hA:    seg7 = 7'h77;
      4'hB:    seg7 = 7'h7C;
      4'hC:    seg7 = 7'h39;
      4'hD:    seg7 = 7'h5E;
      default: seg7 = 7'h00;
    endcase
  endfunction

  function automatic logic [2:0] motor_code(input logic [3:0] code);
    case (code)
      4'hA, 4'h1: motor_code = 3'b001;
      4'hB, 4'h2: motor_code = 3'b010;
      4'hC, 4'h3: motor_code = 3'b100;
      4'hD:       motor_code = 3'b111;
      default:    motor_code = 3'b000;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      scan_cnt_q, scan_cnt_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      rel_cnt_q, rel_cnt_d;
  logic             held_q, held_d;
  logic [15:0]      ref_cnt_q, ref_cnt_d;
  logic [2:0]       en_q, en_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0][3:0]  code_q, code_d;
  logic [2:0]       valid_q, valid_d;
  logic             enter_q;
  logic [1:0]       ptr_q, ptr_d;
  logic [15:0]      tick_q, tick_d;
  logic [2:0]       mot_q, mot_d;

  logic [1:0] row_idx_s, col_idx_s, top_idx_s, disp_sel_s;
  logic [3:0] key_idx_s;
  logic       hit_s, col_end_s, detect_s, start_s, press_s, last_slot_s;

  always_comb begin
    row_idx_s = 2'd3;
    if (fila[0]) begin
      row_idx_s = 2'd0;
    end else if (fila[1]) begin
      row_idx_s = 2'd1;
    end else if (fila[2]) begin
      row_idx_s = 2'd2;
    end else begin
      row_idx_s = 2'd3;
    end
    case (col_q)
      4'b0010: col_idx_s = 2'd1;
      4'b0100: col_idx_s = 2'd2;
      4'b1000: col_idx_s = 2'd3;
      default: col_idx_s = 2'd0;
    endcase
    if (valid_q[2]) begin
      top_idx_s = 2'd2;
    end else if (valid_q[1]) begin
      top_idx_s = 2'd1;
    end else begin
      top_idx_s = 2'd0;
    end
  end

  assign key_idx_s   = {row_idx_s, col_idx_s};
  assign hit_s       = |fila;
  assign col_end_s   = (scan_cnt_q == SCAN_LAST);
  assign start_s     = (state_q == S_IDLE) && enter && !enter_q && (|valid_q);
  assign press_s     = detect_s && !held_q && (state_q == S_IDLE) && !start_s;
  assign last_slot_s = (state_q == S_RUN) && (tick_q == TICK_LAST) && (ptr_q == 2'd0);

`ifdef KEYPAD_DEBOUNCE_EN
  // Candidate key must be seen again on the next scan of its column before it counts.
  logic [3:0] cand_q, cand_d;
  logic       cand_v_q, cand_v_d;

  always_comb begin
    cand_d   = cand_q;
    cand_v_d = cand_v_q;
    if (col_end_s && hit_s) begin
      cand_d   = key_idx_s;
      cand_v_d = 1'b1;
    end else if (col_end_s && cand_v_q && (cand_q[1:0] == col_idx_s)) begin
      cand_v_d = 1'b0;
    end else begin
      cand_v_d = cand_v_q;
    end
  end

  assign detect_s = col_end_s && hit_s && cand_v_q && (cand_q == key_idx_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= 4'd0;
      cand_v_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cand_v_q <= cand_v_d;
    end
  end
`else
  assign detect_s = hit_s;
`endif

  // Scanner, held-key release timer and display multiplexer.
  always_comb begin
    if (col_end_s) begin
      scan_cnt_d = 16'd0;
      col_d      = {col_q[2:0], col_q[3]};
    end else begin
      scan_cnt_d = scan_cnt_q + 16'd1;
      col_d      = col_q;
    end
    if (hit_s) begin
      rel_cnt_d = 16'd0;
    end else if (rel_cnt_q != REL_LAST) begin
      rel_cnt_d = rel_cnt_q + 16'd1;
    end else begin
      rel_cnt_d = rel_cnt_q;
    end
    if (press_s) begin
      held_d = 1'b1;
    end else if (!hit_s && (rel_cnt_q == REL_LAST)) begin
      held_d = 1'b0;
    end else begin
      held_d = held_q;
    end
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = 16'd0;
      en_d      = {en_q[1:0], en_q[2]};
    end else begin
      ref_cnt_d = ref_cnt_q + 16'd1;
      en_d      = en_q;
    end
    case (en_d)
      3'b010:  disp_sel_s = 2'd1;
      3'b100:  disp_sel_s = 2'd2;
      default: disp_sel_s = 2'd0;
    endcase
    if (valid_q[disp_sel_s]) begin
      seg_d = seg7(code_q[disp_sel_s]);
    end else begin
      seg_d = 7'h00;
    end
  end

  always_comb begin
    case (state_q)
      S_IDLE:  state_d = start_s ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_slot_s ? S_IDLE : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer shifting and playback; valid entries are always contiguous from slot 0.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    tick_d  = tick_q;
    mot_d   = mot_q;
    if (start_s) begin
      ptr_d  = top_idx_s;
      tick_d = 16'd0;
      mot_d  = motor_code(code_q[top_idx_s]);
    end else if (state_q == S_RUN) begin
      if (tick_q != TICK_LAST) begin
        tick_d = tick_q + 16'd1;
      end else if (ptr_q == 2'd0) begin
        tick_d  = 16'd0;
        mot_d   = 3'b000;
        code_d  = '0;
        valid_d = 3'b000;
      end else begin
        tick_d = 16'd0;
        ptr_d  = ptr_q - 2'd1;
        mot_d  = motor_code(code_q[ptr_q - 2'd1]);
      end
    end else if (press_s && key_storable(key_idx_s)) begin
      code_d  = {code_q[1], code_q[0], key_code(key_idx_s)};
      valid_d = {valid_q[1:0], 1'b1};
    end else begin
      mot_d = mot_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      scan_cnt_q <= 16'd0;
      col_q      <= 4'b0001;
      rel_cnt_q  <= 16'd0;
      held_q     <= 1'b0;
      ref_cnt_q  <= 16'd0;
      en_q       <= 3'b001;
      seg_q      <= 7'h00;
      code_q     <= '0;
      valid_q    <= 3'b000;
      enter_q    <= 1'b0;
      ptr_q      <= 2'd0;
      tick_q     <= 16'd0;
      mot_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      col_q      <= col_d;
      rel_cnt_q  <= rel_cnt_d;
      held_q     <= held_d;
      ref_cnt_q  <= ref_cnt_d;
      en_q       <= en_d;
      seg_q      <= seg_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      enter_q    <= enter;
      ptr_q      <= ptr_d;
      tick_q     <= tick_d;
      mot_q      <= mot_d;
    end
  end

  assign col       = col_q;
  assign enable    = en_q;
  assign segmentos = seg_q;
  assign Motores   = mot_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: keypad model driving fila from col, queue-based buffer model.
module tb_top;

  logic       clk;
  logic       reset;
  logic       enter;
  logic [3:0] fila;
  logic [3:0] col;
  logic [2:0] Motores;
  logic [6:0] segmentos;
  logic [2:0] enable;

  logic       key_down;
  logic [1:0] key_row;
  logic [1:0] key_col;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int model_buf[$];

  // Keypad legend by row*4+col; -1 and -2 stand for '*' and '#'.
  int km[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, -1, 0, -2, 13};
  logic [6:0] seg_tab[14] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                              7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E};

  top #(.SCAN_DIV(1), .REFRESH_DIV(4), .MOTOR_TICKS(16)) dut (
    .clk(clk), .reset(reset), .fila(fila), .col(col), .enter(enter),
    .Motores(Motores), .segmentos(segmentos), .enable(enable)
  );

  always #5 clk = ~clk;

  // A held key closes its row only while its column is driven.
  assign fila = (key_down && col[key_col]) ? (4'b0001 << key_row) : 4'b0000;

  function automatic logic [2:0] motor_of(input int code);
    if (code == 10) return 3'b001;
    if (code == 11) return 3'b010;
    if (code == 12) return 3'b100;
    if (code == 13) return 3'b111;
    if (code >= 1 && code <= 3) return 3'(1 << (code - 1));
    return 3'b000;
  endfunction

  function automatic logic [6:0] seg_of_slot(input int slot);
    if (slot < model_buf.size()) return seg_tab[model_buf[slot]];
    return 7'h00;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_display(input int n);
    logic [1:0] ci;
    logic [1:0] ei;
    repeat (n) begin
      step(1);
      ci = 2'(cyc % 4);
      ei = 2'((cyc / 4) % 3);
      chk("col", {4'b0000, col}, {4'b0000, 4'b0001 << ci});
      chk("enable", {5'b00000, enable}, {5'b00000, 3'b001 << ei});
      chk("segmentos", {1'b0, segmentos}, {1'b0, seg_of_slot(int'(ei))});
    end
  endtask

  task automatic press_idx(input int idx);
    key_row  = 2'(idx / 4);
    key_col  = 2'(idx % 4);
    key_down = 1'b1;
    step(8);
    key_down = 1'b0;
    step(8);
    if (km[idx] >= 0) begin
      model_buf.push_front(km[idx]);
      if (model_buf.size() > 3) void'(model_buf.pop_back());
    end
  endtask

  task automatic playback(input bit inject);
    int n;
    logic [2:0] exp_m;
    n = model_buf.size();
    enter = 1'b1;
    step(1);
    enter = 1'b0;
    for (int s = 0; s < n; s++) begin
      exp_m = motor_of(model_buf[n - 1 - s]);
      for (int t = 0; t < 16; t++) begin
        if (inject && s == 0 && t == 2) begin
          key_row  = 2'd0;
          key_col  = 2'd0;
          key_down = 1'b1;
        end
        if (inject && s == 0 && t == 10) key_down = 1'b0;
        chk("motor_slot", {5'b00000, Motores}, {5'b00000, exp_m});
        step(1);
      end
    end
    chk("motor_done", {5'b00000, Motores}, 8'h00);
    model_buf.delete();
  endtask

  task automatic enter_no_effect();
    enter = 1'b1;
    step(1);
    enter = 1'b0;
    repeat (20) begin
      chk("motor_idle", {5'b00000, Motores}, 8'h00);
      step(1);
    end
  endtask

  initial begin
    int n;
    int idx;
    clk      = 1'b0;
    reset    = 1'b1;
    enter    = 1'b0;
    key_down = 1'b0;
    key_row  = 2'd0;
    key_col  = 2'd0;

    step(3);
    chk("rst_col", {4'b0000, col}, 8'h01);
    chk("rst_enable", {5'b00000, enable}, 8'h01);
    chk("rst_seg", {1'b0, segmentos}, 8'h00);
    chk("rst_motor", {5'b00000, Motores}, 8'h00);
    reset = 1'b0;
    cyc   = 0;
    check_display(12);

    // A, B, C on column 1000, rows 0..2; key '1' pressed during playback must be ignored.
    press_idx(3);
    press_idx(7);
    press_idx(11);
    check_display(12);
    playback(1'b1);
    check_display(12);

    enter_no_effect();
    check_display(12);

    // Four keys overflow the buffer: the first one drops out.
    press_idx(0);
    press_idx(1);
    press_idx(2);
    press_idx(4);
    check_display(12);
    playback(1'b0);
    check_display(12);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      repeat (n) begin
        do idx = $urandom_range(0, 15); while (idx == 12 || idx == 14);
        press_idx(idx);
      end
      check_display(12);
      playback(1'b0);
      check_display(12);
    end

    // Reset in the middle of playback.
    press_idx(15);
    press_idx(1);
    press_idx(9);
    enter = 1'b1;
    step(1);
    enter = 1'b0;
    step(5);
    chk("run_motor", {5'b00000, Motores}, {5'b00000, motor_of(model_buf[model_buf.size() - 1])});
    reset = 1'b1;
    #1;
    chk("midrun_motor", {5'b00000, Motores}, 8'h00);
    chk("midrun_col", {4'b0000, col}, 8'h01);
    chk("midrun_enable", {5'b00000, enable}, 8'h01);
    chk("midrun_seg", {1'b0, segmentos}, 8'h00);
    step(2);
    reset = 1'b0;
    cyc   = 0;
    model_buf.delete();
    check_display(12);
    enter_no_effect();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
